imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory loader for the 8-bit pipelined processor. It accepts a length-prefixed byte stream over a valid/ready handshake and writes the bytes into consecutive instruction-memory locations starting at address 0. It holds the processor in reset until the image is written. It is the write-side counterpart of the instruction fetch stage, which only reads that memory.

## Interface
Parameters:
- ADDR_W, 4, instruction-memory address width; DEPTH = 2**ADDR_W words of 8 bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one cycle per byte.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- busy  output  1  load in progress.
- done  output  1  image written successfully; level.
- err  output  1  load aborted; level.
- proc_hold  output  1  holds the processor pipeline in reset; the top level ORs it into the pipeline `rst`.

## Operation
- States:
  - IDLE: in_ready=0, busy=0. start → LEN.
  - LEN: in_ready=1, busy=1. On accept:
    - in_data==0 or in_data>DEPTH → ERR.
    - Otherwise cnt←in_data, wptr←0, sum←0, → DATA.
  - DATA: in_ready=1, busy=1. On accept:
    - Registered write with mem_addr=wptr and mem_wdata=in_data.
    - wptr++, cnt--, sum←sum+in_data (mod 256).
    - When cnt reaches 0 → FIN. Under LOADER_CHECKSUM_EN, → CSUM instead.
  - CSUM (macro only): in_ready=1, busy=1. On accept, (sum+in_data) mod 256 == 0 → FIN; otherwise → ERR.
  - FIN: one cycle, in_ready=0, busy=1 (drains the final write) → DONE.
  - DONE: done=1, proc_hold=0, busy=0. start → LEN. On that transition done clears and proc_hold sets.
  - ERR: err=1, proc_hold=1, busy=0. start → LEN and clears err.
- Handshake:
  - A transfer occurs only when in_valid && in_ready on a rising edge.
  - in_ready depends only on state, never on in_valid.
  - in_data is ignored when no transfer occurs.
- start is ignored in LEN/DATA/CSUM/FIN; a load in progress cannot be restarted except by rst.
- wptr is ADDR_W+1 bits internally. A length of DEPTH writes addresses 0..DEPTH-1 and never wraps.
- Writes to the memory happen only via mem_we. Addresses beyond the loaded length keep their previous contents.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, proc_hold=1; state IDLE, cnt=0, wptr=0, sum=0.
- Byte accepted in cycle T → mem_we=1 with its address and data in cycle T+1, for exactly one cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Back-to-back accepts give back-to-back writes: one byte per cycle sustained.
- Last data byte, or the checksum byte, accepted in cycle T:
  - Without the macro: the final write is in T+1 (the FIN cycle).
  - done=1 and proc_hold=0 from T+2 onward.
- ERR is entered the cycle after the offending accept; err=1 from then on. A write already issued for an earlier byte still completes.
- start in the same cycle as DONE→LEN: done and err fall, and proc_hold rises, at the next edge.
- rst asserted mid-load: at the next edge everything returns to reset values, and any pending write is dropped (mem_we=0).

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The stream is a length byte, N data bytes, then one checksum byte. The CSUM state and the sum register are present.
  - A checksum mismatch → ERR. proc_hold stays 1 and the memory contents already written are left as-is.
- Not defined: the stream is a length byte plus N data bytes. No CSUM state and no sum register; FIN follows the last data byte.

## Test plan
- Basic load, no macro: rst, start, stream 03,A1,B2,C3 with in_valid always 1.
  - Writes (0,A1),(1,B2),(2,C3) on consecutive cycles.
  - done=1 and proc_hold=0 two cycles after the C3 accept.
- Backpressure gaps: same stream with in_valid toggling 1/0.
  - Exactly 3 writes, same addresses and data; no write in any idle cycle.
- Bad length:
  - Length 00 → err=1, no mem_we.
  - Length DEPTH+1 (0x11 with ADDR_W=4) → err=1, proc_hold=1.
- Full depth: length 0x10, data 00..0F → 16 writes at addresses 0..15, last address 15, done=1.
- Checksum (macro on):
  - 02,10,20,D0 → done=1.
  - 02,10,20,D1 → err=1 after two writes; a subsequent start plus valid stream → done=1.
- Reset mid-load: rst asserted after the second data byte of a 5-byte load → all outputs at reset values next cycle, no further writes, proc_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream in, sequential memory writes out.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte that must bring the byte sum to zero.
module imem_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              proc_hold
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        FIN,
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [7:0]      cnt;
    logic [ADDR_W:0] wptr;
    logic            xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      sum;
    logic [7:0]      sum_total;
`endif

    // Next-state decode; the registered outputs below are derived from it so they line up with state.
    always_comb begin
        state_n = state;
        xfer    = in_valid && in_ready;
`ifdef LOADER_CHECKSUM_EN
        sum_total = sum + in_data;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (start)
                    state_n = LEN;
            end
            LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0 || int'(in_data) > DEPTH)
                        state_n = ERR;
                    else
                        state_n = DATA;
                end
            end
            DATA: begin
                if (xfer && cnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = CSUM;
`else
                    state_n = FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer)
                    state_n = (sum_total == 8'd0) ? FIN : ERR;
            end
`endif
            FIN:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            wptr      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            proc_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            mem_we    <= 1'b0;
            done      <= (state_n == DONE);
            err       <= (state_n == ERR);
            proc_hold <= (state_n != DONE);
            busy      <= (state_n == LEN) || (state_n == DATA) || (state_n == FIN)
`ifdef LOADER_CHECKSUM_EN
                         || (state_n == CSUM)
`endif
                         ;
            in_ready  <= (state_n == LEN) || (state_n == DATA)
`ifdef LOADER_CHECKSUM_EN
                         || (state_n == CSUM)
`endif
                         ;

            if (state == LEN && xfer && state_n == DATA) begin
                cnt  <= in_data;
                wptr <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum  <= 8'd0;
`endif
            end

            // The extra pointer bit can only be set after the last legal address, so it gates the write.
            if (state == DATA && xfer) begin
                mem_we    <= !wptr[ADDR_W];
                mem_addr  <= wptr[ADDR_W-1:0];
                mem_wdata <= in_data;
                wptr      <= wptr + (ADDR_W+1)'(1);
                cnt       <= cnt - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                sum       <= sum + in_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as data bytes are sent
// and popped when the loader drives mem_we.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       proc_hold;

    int testsRun  = 0;
    int testsFail = 0;
    int writeCount = 0;
    int cycle = 0;
    int firstWriteCycle = -1;
    int lastWriteCycle = -1;
    logic [3:0] lastAddr = 4'd0;

    logic [11:0] expQ[$];
    logic [7:0]  stim[$];

    imem_loader #(.ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .proc_hold(proc_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            writeCount++;
            if (firstWriteCycle < 0)
                firstWriteCycle = cycle;
            lastWriteCycle = cycle;
            lastAddr = mem_addr;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = expQ.pop_front();
                checkOutput("waddr", 32'(mem_addr), 32'(e[11:8]));
                checkOutput("wdata", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Presents one byte, waits (bounded) for in_ready, then idles for gap cycles.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50)
            checkOutput("ready_timeout", 32'd1, 32'd0);
        tick(1);
        in_valid = 1'b0;
        in_data  = 8'hxx;
        if (gap > 0)
            tick(gap);
    endtask

    // Sends stim[], queueing expected writes for the first nWrites bytes after the length.
    task automatic applyStimulus(input int nWrites, input int gap);
        firstWriteCycle = -1;
        lastWriteCycle  = -1;
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 1 && i <= nWrites)
                expQ.push_back({4'(i - 1), stim[i]});
            sendByte(stim[i], gap);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_proc_hold"}, 32'(proc_hold), 32'd1);
    endtask

    initial begin
        int wc;
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int wc;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        tick(2);
        rst = 1'b0;
        checkResetState("reset");

        // Basic load, in_valid held high
        pulseStart();
        checkOutput("len_in_ready", 32'(in_ready), 32'd1);
        checkOutput("len_busy", 32'(busy), 32'd1);
        wc = writeCount;
        stim = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
        applyStimulus(3, 0);
        checkOutput("fin_busy", 32'(busy), 32'd1);
        checkOutput("fin_done", 32'(done), 32'd0);
        checkOutput("fin_in_ready", 32'(in_ready), 32'd0);
        tick(1);
        checkOutput("basic_done", 32'(done), 32'd1);
        checkOutput("basic_hold", 32'(proc_hold), 32'd0);
        checkOutput("basic_busy", 32'(busy), 32'd0);
        checkOutput("basic_writes", 32'(writeCount - wc), 32'd3);
        checkOutput("basic_b2b", 32'(lastWriteCycle - firstWriteCycle), 32'd2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_hold", 32'(proc_hold), 32'd1);

        // Same image with backpressure gaps, already in LEN
        wc = writeCount;
        applyStimulus(3, 1);
        tick(2);
        checkOutput("gap_done", 32'(done), 32'd1);
        checkOutput("gap_writes", 32'(writeCount - wc), 32'd3);

        // Zero length
        pulseStart();
        wc = writeCount;
        stim = '{8'h00};
        applyStimulus(0, 0);
        checkOutput("len0_err", 32'(err), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        tick(2);
        checkOutput("len0_writes", 32'(writeCount - wc), 32'd0);

        // Length one beyond the memory depth
        pulseStart();
        checkOutput("err_cleared", 32'(err), 32'd0);
        stim = '{8'h11};
        applyStimulus(0, 0);
        checkOutput("len17_err", 32'(err), 32'd1);
        checkOutput("len17_hold", 32'(proc_hold), 32'd1);
        checkOutput("len17_done", 32'(done), 32'd0);

        // Full depth image
        pulseStart();
        wc = writeCount;
        stim = '{8'h10};
        for (int i = 0; i < 16; i++)
            stim.push_back(8'(i));
        applyStimulus(16, 0);
        tick(1);
        checkOutput("full_done", 32'(done), 32'd1);
        checkOutput("full_writes", 32'(writeCount - wc), 32'd16);
        checkOutput("full_last_addr", 32'(lastAddr), 32'd15);

`ifdef LOADER_CHECKSUM_EN
        pulseStart();
        stim = '{8'h02, 8'h10, 8'h20, 8'hD0};
        applyStimulus(2, 0);
        tick(1);
        checkOutput("csum_ok_done", 32'(done), 32'd1);

        pulseStart();
        wc = writeCount;
        stim = '{8'h02, 8'h10, 8'h20, 8'hD1};
        applyStimulus(2, 0);
        checkOutput("csum_bad_err", 32'(err), 32'd1);
        checkOutput("csum_bad_hold", 32'(proc_hold), 32'd1);
        checkOutput("csum_bad_writes", 32'(writeCount - wc), 32'd2);

        pulseStart();
        stim = '{8'h02, 8'h10, 8'h20, 8'hD0};
        applyStimulus(2, 0);
        tick(1);
        checkOutput("csum_retry_done", 32'(done), 32'd1);
`endif

        // Reset mid-load after the second data byte of a 5-byte image
        pulseStart();
        stim = '{8'h05, 8'h11, 8'h22};
        applyStimulus(2, 0);
        rst = 1'b1;
        tick(1);
        checkResetState("midrst");
        rst = 1'b0;
        wc = writeCount;
        in_valid = 1'b1;
        in_data = 8'h33;
        tick(4);
        in_valid = 1'b0;
        checkOutput("midrst_no_writes", 32'(writeCount - wc), 32'd0);
        checkOutput("midrst_hold", 32'(proc_hold), 32'd1);

        tick(2);
        checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
